hir_mem_responder: RTL
======================

HIR_MEM_RESPONDER -- requirements
Module: hir_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the kernel and host address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width of every data port.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning the number of memory words (at most 2^ADDR_W).
REQ-004 The block SHALL have parameter EXP_WRITES, default 256, meaning the number of kernel writes that completes a run.
REQ-005 The block SHALL have parameter TIMEOUT, default 4096, meaning the maximum number of RUN cycles before abort.
REQ-006 Port clk, in, 1 bit: the single clock; one clock; all logic on its rising edge.
REQ-007 Port rst, in, 1 bit: reset; reset is synchronous and active-high.
REQ-008 Port start, in, 1 bit: host launch request.
REQ-009 Port tstart, out, 1 bit: kernel start pulse.
REQ-010 Port rd_addr, in, ADDR_W bits: kernel read address.
REQ-011 Port rd_en, in, 1 bit: kernel read enable.
REQ-012 Port rd_data, out, DATA_W bits: kernel read data.
REQ-013 Port wr_addr, in, ADDR_W bits: kernel write address.
REQ-014 Port wr_en, in, 1 bit: kernel write enable.
REQ-015 Port wr_data, in, DATA_W bits: kernel write data.
REQ-016 Port host_wr_en, in, 1 bit: host preload write enable.
REQ-017 Port host_addr, in, ADDR_W bits: host preload or readback address.
REQ-018 Port host_wr_data, in, DATA_W bits: host preload data.
REQ-019 Port host_rd_data, out, DATA_W bits: host readback data.
REQ-020 Port busy, out, 1 bit: state is LAUNCH or RUN.
REQ-021 Port done, out, 1 bit: state is DONE.
REQ-022 Port timeout, out, 1 bit: the last run was aborted by timeout.
REQ-023 Port wr_count, out, 16 bits: number of kernel writes in the current or last run.
REQ-024 Port collision, out, 1 bit: sticky read/write same-address flag.

Function
REQ-025 The FSM SHALL have states IDLE, LAUNCH, RUN and DONE.
- IDLE/DONE + start -> LAUNCH.
- LAUNCH -> RUN after exactly 1 cycle.
- RUN -> DONE when wr_count reaches EXP_WRITES, or when the cycle counter reaches TIMEOUT.
REQ-026 tstart SHALL be 1 for exactly the single LAUNCH cycle and 0 otherwise.
REQ-027 start during LAUNCH or RUN SHALL be ignored.
REQ-028 Entering LAUNCH SHALL clear wr_count, the cycle counter, timeout and collision.
REQ-029 rd_en=1 at cycle N SHALL give rd_data = mem[rd_addr] at N+1; rd_data SHALL hold its value while rd_en=0.
REQ-030 A kernel read and write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-031 Kernel writes SHALL update memory in any state; only writes in RUN SHALL increment wr_count.
REQ-032 wr_count SHALL saturate at EXP_WRITES.
REQ-033 The write that reaches EXP_WRITES SHALL be applied, and the FSM SHALL be in DONE on the next cycle.
REQ-034 If count completion and timeout occur in the same cycle, the block SHALL go to DONE with timeout=0.
REQ-035 host_wr_en SHALL be honoured only in IDLE or DONE and ignored while busy.
REQ-036 host_rd_data SHALL equal mem[host_addr] registered, with 1-cycle latency, in every state.
REQ-037 An address >= DEPTH SHALL read as 0 and SHALL drop the write.

Reset
REQ-038 rst SHALL put the FSM in IDLE and set tstart, rd_data, host_rd_data, busy, done, timeout, wr_count and collision to 0, including mid-run.
REQ-039 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-040 Macro HIR_MEM_COLLISION_CHECK_EN SHALL control collision detection.
- Defined: in RUN, rd_en & wr_en & rd_addr==wr_addr sets collision sticky until the next LAUNCH or reset.
- Undefined: collision is tied to 0 and no compare logic exists.

Structure
REQ-041 The package hir_mem_pkg SHALL hold the FSM state enum and the default width/depth constants.
REQ-042 One sub-module, hir_mem_ram (two-port synchronous RAM: one read/write port plus one host port), SHALL hold the storage; the FSM and counters SHALL be in the top.

Verification
REQ-043 Preload mem[i]=i for i=0..255, start, then kernel reads addr 5 -> rd_data=5 one cycle after rd_en.
REQ-044 Start -> tstart high exactly 1 cycle, 1 cycle after start; busy=1 from the cycle after start.
REQ-045 256 kernel writes mem[a]=a+100 -> done=1 the cycle after the 256th write, wr_count=256, timeout=0; host readback of addr 7 gives 107.
REQ-046 Start with no writes for 4096 cycles -> done=1, timeout=1, wr_count=0.
REQ-047 Read and write addr 3 in the same cycle with old value 3 -> rd_data=3, mem[3]=new value; collision=1 only when HIR_MEM_COLLISION_CHECK_EN is defined.
REQ-048 rst asserted mid-RUN after 10 writes -> IDLE with all outputs 0; preloaded/written memory values remain intact on readback.

Source files
------------

// File: rtl/hir_mem_pkg.sv
// Shared types and default sizing for the HIR memory responder.
// Optional collision detection is built only with HIR_MEM_COLLISION_CHECK_EN.
package hir_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_EXP_WRITES = 256;
  localparam int DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/hir_mem_responder_if.sv
// Kernel and host handshake bundle for the HIR memory responder.
// Optional collision detection is built only with HIR_MEM_COLLISION_CHECK_EN.
interface hir_mem_responder_if
  import hir_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic              tstart;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              host_wr_en;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic [DATA_W-1:0] host_rd_data;

  modport master (
    output start, rd_addr, rd_en, wr_addr, wr_en, wr_data,
           host_wr_en, host_addr, host_wr_data,
    input  tstart, rd_data, host_rd_data
  );

  modport slave (
    input  start, rd_addr, rd_en, wr_addr, wr_en, wr_data,
           host_wr_en, host_addr, host_wr_data,
    output tstart, rd_data, host_rd_data
  );

endinterface

// File: rtl/hir_mem_ram.sv
// Two-port synchronous RAM: kernel read/write port plus host port.
// Optional collision detection (HIR_MEM_COLLISION_CHECK_EN) lives in the top, not here.
module hir_mem_ram
  import hir_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic [DATA_W-1:0] host_rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic rd_ok, wr_ok, host_ok;

  // Out-of-range addresses only exist when DEPTH is smaller than the address space.
  generate
    if (DEPTH >= (1 << ADDR_W)) begin : g_full
      assign rd_ok   = 1'b1;
      assign wr_ok   = 1'b1;
      assign host_ok = 1'b1;
    end else begin : g_part
      assign rd_ok   = rd_addr   < ADDR_W'(DEPTH);
      assign wr_ok   = wr_addr   < ADDR_W'(DEPTH);
      assign host_ok = host_addr < ADDR_W'(DEPTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
    if (host_wr_en && host_ok) mem[host_addr] <= host_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data      <= '0;
      host_rd_data <= '0;
    end else begin
      if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;
      host_rd_data <= host_ok ? mem[host_addr] : '0;
    end
  end

endmodule

// File: rtl/hir_mem_responder.sv
// HIR kernel memory responder: launch/run/done sequencing around a shared RAM.
// Define HIR_MEM_COLLISION_CHECK_EN to build the same-address read/write collision flag.
//
// state  | meaning
// IDLE   | waiting for start, host may preload
// LAUNCH | single-cycle kernel start pulse, counters cleared
// RUN    | kernel active, writes counted, timeout timer running
// DONE   | run finished (count reached or timed out), host may read back
module hir_mem_responder
  import hir_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int EXP_WRITES = DEF_EXP_WRITES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  hir_mem_responder_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [15:0]         wr_count,
  output logic                collision
);

  localparam int              CYC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0]     EXP_CNT  = 16'(EXP_WRITES);
  localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(TIMEOUT - 1);

  state_t           state;
  logic [CYC_W-1:0] cyc_left;
  logic             tstart_q;
  logic             launch_req, count_hit, time_hit, host_we;

  assign launch_req = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign count_hit  = bus.wr_en && (wr_count == EXP_CNT - 16'd1);
  assign time_hit   = (cyc_left == '0);
  assign host_we    = bus.host_wr_en && (state == ST_IDLE || state == ST_DONE);
  assign bus.tstart = tstart_q;

  // Timer counts down the remaining RUN cycles; zero marks the last allowed cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tstart_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      wr_count <= '0;
      cyc_left <= CYC_LOAD;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch_req) begin
            state    <= ST_LAUNCH;
            tstart_q <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            timeout  <= 1'b0;
            wr_count <= '0;
            cyc_left <= CYC_LOAD;
          end
        end
        ST_LAUNCH: begin
          state    <= ST_RUN;
          tstart_q <= 1'b0;
        end
        ST_RUN: begin
          if (bus.wr_en && wr_count != EXP_CNT) wr_count <= wr_count + 16'd1;
          if (!time_hit) cyc_left <= cyc_left - CYC_W'(1);
          // Count completion wins over a simultaneous timeout.
          if (count_hit || time_hit) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= !count_hit;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HIR_MEM_COLLISION_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || launch_req) begin
      collision <= 1'b0;
    end else if (state == ST_RUN && bus.rd_en && bus.wr_en && bus.rd_addr == bus.wr_addr) begin
      collision <= 1'b1;
    end
  end
`else
  assign collision = 1'b0;
`endif

  hir_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (bus.rd_en),
    .rd_addr      (bus.rd_addr),
    .rd_data      (bus.rd_data),
    .wr_en        (bus.wr_en),
    .wr_addr      (bus.wr_addr),
    .wr_data      (bus.wr_data),
    .host_wr_en   (host_we),
    .host_addr    (bus.host_addr),
    .host_wr_data (bus.host_wr_data),
    .host_rd_data (bus.host_rd_data)
  );

endmodule
